// File: rtl/square_fixed_point_seq_pkg.sv
// -----------------------------------------------------------------------------
// square_fixed_point_seq_pkg
// Shared types and sizing helpers for the sequential fixed-point re-square
// block (radical = q*q + remainder) and its alignment stage.
//   state_t      : controller states IDLE / MUL / ALIGN / HOLD
//   acc_width    : accumulator width, 2*rootWidth+1 (q=max, rem=max cannot wrap)
//   align_shift  : right shift from the native 2*rootDecWidth fraction to the
//                  requested output fraction
//   cnt_width    : bit-counter width, $clog2(rootWidth+1)
// The block is parameterised, so the sizes are exposed as functions; the top
// turns them into its ACC_W / SHIFT / CNT_W localparams.
// -----------------------------------------------------------------------------
package square_fixed_point_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_ALIGN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  function automatic int acc_width(input int root_w);
    return 2 * root_w + 1;
  endfunction

  function automatic int align_shift(input int root_dec_w, input int out_dec_w);
    return 2 * root_dec_w - out_dec_w;
  endfunction

  function automatic int cnt_width(input int root_w);
    return $clog2(root_w + 1);
  endfunction

endpackage

// File: rtl/square_fixed_point_seq_align.sv
// -----------------------------------------------------------------------------
// fxp_align_sat
// Combinational fixed-point realignment: right-shift by SHIFT (truncating
// toward zero), then saturate to OUT_W bits when any whole-part bit above the
// output range is set.
//   i_data     [IN_W-1:0]  unsigned input value
//   o_data     [OUT_W-1:0] shifted value, or all ones on overflow
//   o_overflow             1 when the output was saturated
// -----------------------------------------------------------------------------
module fxp_align_sat #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic [IN_W-1:0]  i_data,
  output logic [OUT_W-1:0] o_data,
  output logic             o_overflow
);

  logic [IN_W-1:0] w_shifted;

  assign w_shifted = i_data >> SHIFT;

  generate
    if (OUT_W < IN_W) begin : g_sat
      logic w_ovf;
      assign w_ovf      = |w_shifted[IN_W-1:OUT_W];
      assign o_data     = w_ovf ? {OUT_W{1'b1}} : w_shifted[OUT_W-1:0];
      assign o_overflow = w_ovf;
    end else begin : g_wide
      // Output is at least as wide as the input: nothing can overflow.
      assign o_data     = OUT_W'(w_shifted);
      assign o_overflow = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/square_fixed_point_seq.sv
// -----------------------------------------------------------------------------
// square_fixed_point_seq
// Sequential inverse of the fixed-point square root: rebuilds
// radical = q*q + remainder with a one-bit-per-cycle shift-add multiplier,
// realigns it to the requested output format and saturates on overflow.
// Ports:
//   clk, aclr (async, active high)
//   in_valid / in_ready     : operand handshake (one operand in flight)
//   q [rootWidth-1:0]       : root, unsigned fixed point
//   remainder [rootWidth:0] : remainder, LSB weight of the q*q product
//   out_valid / out_ready   : result handshake
//   result [outputWidth-1:0]: realigned q*q+remainder
//   overflow                : result saturated (qualified by out_valid)
//   rem_err                 : remainder > 2*q (qualified by out_valid)
// Latency: out_valid rises rootWidth+1 edges after the accept edge.
// -----------------------------------------------------------------------------
module square_fixed_point_seq
  import square_fixed_point_seq_pkg::*;
#(
  parameter int rootWidth      = 8,
  parameter int rootDecWidth   = 4,
  parameter int outputWidth    = 2 * rootWidth,
  parameter int outputDecWidth = 2 * rootDecWidth
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [rootWidth-1:0]   q,
  input  logic [rootWidth:0]     remainder,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [outputWidth-1:0] result,
  output logic                   overflow,
  output logic                   rem_err
);

  localparam int ACC_W = acc_width(rootWidth);
  localparam int SHIFT = align_shift(rootDecWidth, outputDecWidth);
  localparam int CNT_W = cnt_width(rootWidth);

  generate
    if (outputDecWidth > 2 * rootDecWidth) begin : g_bad_format
      $error("outputDecWidth must not exceed 2*rootDecWidth");
    end
  endgenerate

  state_t                 r_state;
  logic [ACC_W-1:0]       r_acc;
  logic [rootWidth-1:0]   r_mcand;
  logic [rootWidth-1:0]   r_mplier;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rem_err_cap;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [outputWidth-1:0] r_result;
  logic                   r_overflow;
  logic                   r_rem_err;

  logic [ACC_W-1:0]       w_partial;
  logic [outputWidth-1:0] w_aligned;
  logic                   w_aligned_ovf;

  // Partial product for the current multiplier bit, weighted by its position.
  assign w_partial = ACC_W'(r_mcand) << r_cnt;

  fxp_align_sat #(
    .IN_W  (ACC_W),
    .OUT_W (outputWidth),
    .SHIFT (SHIFT)
  ) u_align (
    .i_data     (r_acc),
    .o_data     (w_aligned),
    .o_overflow (w_aligned_ovf)
  );

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_state       <= ST_IDLE;
      r_acc         <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_cnt         <= '0;
      r_rem_err_cap <= 1'b0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_result      <= '0;
      r_overflow    <= 1'b0;
      r_rem_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // in_ready comes up on the first edge after reset release.
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_mcand       <= q;
            r_mplier      <= q;
            r_acc         <= ACC_W'(remainder);
            r_rem_err_cap <= (remainder > {q, 1'b0});
            r_cnt         <= '0;
            r_in_ready    <= 1'b0;
            r_state       <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + w_partial;
          end
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          // No early exit: every operand takes rootWidth MUL cycles.
          if (r_cnt == CNT_W'(rootWidth - 1)) begin
            r_state <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          r_result    <= w_aligned;
          r_overflow  <= w_aligned_ovf;
          r_rem_err   <= r_rem_err_cap;
          r_out_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign rem_err   = r_rem_err;

endmodule

// File: tb/tb_square_fixed_point_seq.sv
// -----------------------------------------------------------------------------
// tb_square_fixed_point_seq
// Directed bench for square_fixed_point_seq. Instance A uses the default
// 16/8 output format, instance B an 8/4 format that can saturate.
// -----------------------------------------------------------------------------
module tb_square_fixed_point_seq;

  logic        clk;
  logic        aclr;
  logic [7:0]  drv_q;
  logic [8:0]  drv_rem;
  logic        drv_valid;
  logic        drv_ordy;
  bit          cur_sel;

  logic        a_in_valid, a_in_ready, a_out_valid, a_overflow, a_rem_err;
  logic [15:0] a_result;
  logic        b_in_valid, b_in_ready, b_out_valid, b_overflow, b_rem_err;
  logic [7:0]  b_result;

  int n_tests = 0;
  int n_fail  = 0;

  assign a_in_valid = drv_valid & ~cur_sel;
  assign b_in_valid = drv_valid & cur_sel;

  logic        w_rdy, w_ov, w_ovf, w_err;
  logic [15:0] w_res;
  assign w_rdy = cur_sel ? b_in_ready  : a_in_ready;
  assign w_ov  = cur_sel ? b_out_valid : a_out_valid;
  assign w_ovf = cur_sel ? b_overflow  : a_overflow;
  assign w_err = cur_sel ? b_rem_err   : a_rem_err;
  assign w_res = cur_sel ? {8'h00, b_result} : a_result;

  square_fixed_point_seq #(
    .rootWidth(8), .rootDecWidth(4), .outputWidth(16), .outputDecWidth(8)
  ) dut_a (
    .clk(clk), .aclr(aclr), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .q(drv_q), .remainder(drv_rem), .out_valid(a_out_valid),
    .out_ready(drv_ordy), .result(a_result), .overflow(a_overflow),
    .rem_err(a_rem_err)
  );

  square_fixed_point_seq #(
    .rootWidth(8), .rootDecWidth(4), .outputWidth(8), .outputDecWidth(4)
  ) dut_b (
    .clk(clk), .aclr(aclr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .q(drv_q), .remainder(drv_rem), .out_valid(b_out_valid),
    .out_ready(drv_ordy), .result(b_result), .overflow(b_overflow),
    .rem_err(b_rem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: accept, latency, result, optional back-pressure
  // of `hold` cycles (with in_valid kept high to prove it is ignored), release.
  task automatic do_op(input bit sel, input logic [7:0] qq, input logic [8:0] rr,
                       input logic [15:0] er, input logic eo, input logic ee,
                       input int hold, input string tag);
    int w;
    int lat;
    cur_sel  = sel;
    drv_ordy = (hold == 0);
    w = 0;
    while (!w_rdy && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, "_rdy"}, 32'(w_rdy), 32'd1);
    drv_q     = qq;
    drv_rem   = rr;
    drv_valid = 1'b1;
    @(posedge clk); #1;                      // accept edge (cycle 0)
    drv_valid = (hold > 0);
    drv_q     = qq ^ 8'h5A;
    drv_rem   = 9'h1FF;
    lat = 0;
    while (!w_ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd9);
    chk({tag, "_res"}, 32'(w_res), 32'(er));
    chk({tag, "_ovf"}, 32'(w_ovf), 32'(eo));
    chk({tag, "_err"}, 32'(w_err), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_ov"},  32'(w_ov),  32'd1);
      chk({tag, "_hold_res"}, 32'(w_res), 32'(er));
      chk({tag, "_hold_rdy"}, 32'(w_rdy), 32'd0);
    end
    drv_valid = 1'b0;
    drv_ordy  = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_drop_ov"}, 32'(w_ov),  32'd0);
    chk({tag, "_ret_rdy"}, 32'(w_rdy), 32'd1);
    $display("[TB] %s dut=%0d q=%02h rem=%03h result=%04h ovf=%0d err=%0d lat=%0d",
             tag, sel, qq, rr, w_res, w_ovf, w_err, lat);
  endtask

  initial begin
    int qi;
    int ri;
    bit seen;
    aclr = 1'b1; drv_q = '0; drv_rem = '0; drv_valid = 1'b0;
    drv_ordy = 1'b1; cur_sel = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(a_in_ready),  32'd0);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_result",    32'(a_result),    32'd0);
    chk("rst_overflow",  32'(a_overflow),  32'd0);
    chk("rst_rem_err",   32'(a_rem_err),   32'd0);
    aclr = 1'b0;
    #1 chk("rel_in_ready_low", 32'(a_in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_high", 32'(a_in_ready), 32'd1);

    // Main function, default format
    do_op(1'b0, 8'h18, 9'd0, 16'h0240, 1'b0, 1'b0, 0, "q1p5");
    do_op(1'b0, 8'h10, 9'd5, 16'h0105, 1'b0, 1'b0, 0, "q1_r5");
    do_op(1'b0, 8'h02, 9'd5, 16'h0009, 1'b0, 1'b1, 0, "q2_r5_err");
    do_op(1'b0, 8'h00, 9'd0, 16'h0000, 1'b0, 1'b0, 0, "zero");
    do_op(1'b0, 8'hFF, 9'h1FE, 16'hFFFF, 1'b0, 1'b0, 0, "max");

    // 8/4 format: saturation boundary
    do_op(1'b1, 8'hFF, 9'd0, 16'h00FF, 1'b1, 1'b0, 0, "b_sat");
    do_op(1'b1, 8'h3F, 9'd0, 16'h00F8, 1'b0, 1'b0, 0, "b_nosat");

    // Back-pressure
    do_op(1'b0, 8'h10, 9'd5, 16'h0105, 1'b0, 1'b0, 5, "bp");

    // Reset pulsed mid-MUL discards the operand
    cur_sel = 1'b0;
    chk("abort_rdy", 32'(w_rdy), 32'd1);
    drv_q = 8'hFF; drv_rem = 9'd0; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 aclr = 1'b1;
    #1;
    chk("abort_in_ready",  32'(a_in_ready),  32'd0);
    chk("abort_out_valid", 32'(a_out_valid), 32'd0);
    @(posedge clk); #1 aclr = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (a_out_valid) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    chk("abort_rdy_back",  32'(a_in_ready), 32'd1);
    do_op(1'b0, 8'h18, 9'd0, 16'h0240, 1'b0, 1'b0, 0, "after_abort");

    // Loopback with legal sqrt pairs: radical = q*q + r, r <= 2q
    for (int i = 0; i < 1000; i++) begin
      qi = int'($urandom_range(255, 0));
      ri = int'($urandom_range(2 * qi, 0));
      do_op(1'b0, 8'(qi), 9'(ri), 16'(qi * qi + ri), 1'b0, 1'b0, 0, "loop");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/square_fixed_point_seq.md
Name: square_fixed_point_seq

Overview:
- Sequential inverse of the fixed-point square-root block: reconstructs the radical from a root/remainder pair as radical = q*q + remainder.
- Realigns the result to a requested output fixed-point format, saturating on whole-part overflow.
- Used as the companion stage that re-squares sqrt results, for loopback self-check and for magnitude^2 paths.
- Iterative shift-add multiplier, one bit per cycle, with valid/ready handshakes on both sides.

Parameters:
- rootWidth, 8: width of input root q.
- rootDecWidth, 4: fractional bits of q. The full result therefore has 2*rootDecWidth fractional bits.
- outputWidth, 2*rootWidth: width of result.
- outputDecWidth, 2*rootDecWidth: fractional bits of result. Must be <= 2*rootDecWidth; elaboration fails otherwise.

Ports:
- clk  in  1  clock.
- aclr  in  1  asynchronous active-high reset.
- in_valid  in  1  q/remainder valid.
- in_ready  out  1  block can accept an operand.
- q  in  rootWidth  root, unsigned fixed point.
- remainder  in  rootWidth+1  remainder, same LSB weight as the q*q product LSB.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  outputWidth  realigned q*q+remainder.
- overflow  out  1  result saturated, qualified by out_valid.
- rem_err  out  1  remainder > 2*q (not a legal sqrt pair), qualified by out_valid.

Behaviour:
- **Reset (aclr=1, asynchronous):**
  - State goes to IDLE.
  - in_ready=0 while aclr is high, then 1 from the first clk edge after release.
  - out_valid=0, result=0, overflow=0, rem_err=0.
  - The accumulator, multiplicand and counter clear.
  - Reset mid-operation discards the operand silently; no partial result is ever presented.
- **States:** IDLE, MUL, ALIGN, HOLD.
- **IDLE:**
  - in_ready=1.
  - On in_valid&in_ready, capture q into the multiplicand and the multiplier shift register.
  - Capture remainder as the accumulator initial value, zero-extended to 2*rootWidth+1 bits.
  - Compute rem_err_r = (remainder > {q,1'b0}).
  - Set counter=0 and go to MUL.
- **MUL:**
  - in_ready=0.
  - Each cycle: if multiplier LSB=1, acc += multiplicand << counter. Then shift the multiplier right and increment counter.
  - After rootWidth cycles (counter==rootWidth-1 processed), go to ALIGN.
- **ALIGN (one cycle):**
  - Compute shifted = acc >> (2*rootDecWidth - outputDecWidth), truncating toward zero.
  - If any bit of shifted above outputWidth-1 is set: result = all ones, overflow=1. Otherwise result = shifted[outputWidth-1:0], overflow=0.
  - rem_err = rem_err_r. Set out_valid=1 and go to HOLD.
- **HOLD:**
  - result, overflow and rem_err are held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid=0 next cycle and go to IDLE.
  - in_ready stays 0 in HOLD; no skid buffer, so one operand is in flight at a time.
- **Latency:**
  - Accept edge at cycle 0; out_valid rises after the edge at cycle rootWidth+1, i.e. rootWidth MUL cycles plus 1 ALIGN cycle.
  - Minimum initiation interval is rootWidth+3 cycles with out_ready tied high.
- **Arithmetic:**
  - Accumulator width is 2*rootWidth+1, so q=max with remainder=max cannot wrap.
  - rem_err does not alter result; the sum is still reported.
  - q=0 with remainder=0 gives result 0 after the full latency; there is no early exit, so latency is constant.
- **Boundaries:**
  - in_valid asserted while busy is ignored; upstream must hold it until in_ready.
  - out_ready already high when out_valid rises completes the transfer in that cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/MUL/ALIGN/HOLD);
  - the localparams ACC_W = 2*rootWidth+1 and SHIFT = 2*rootDecWidth-outputDecWidth;
  - the counter width $clog2(rootWidth+1).
- One natural sub-module: fxp_align_sat (combinational right-shift, truncate, saturate, overflow flag), reusable by other fixed-point stages.

Test Plan (rootWidth=8, rootDecWidth=4 unless stated):
- Default format (16/8), q=0x18 (1.5), remainder=0 -> result=0x0240 (2.25), overflow=0, rem_err=0, out_valid exactly 9 cycles after accept.
- q=0x10 (1.0), remainder=5 -> result=0x0105, rem_err=0. Then q=0x02, remainder=5 -> result=0x0009, rem_err=1.
- outputWidth=8, outputDecWidth=4, q=0xFF, remainder=0 -> 65025>>4=4064 > 255, so result=0xFF, overflow=1. Then q=0x3F -> 3969>>4=248, so result=0xF8, overflow=0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0 throughout. Release -> out_valid drops next cycle and in_ready returns to 1.
- aclr pulsed during MUL on cycle 4 -> out_valid never rises for that operand. Next operand q=0x18 yields 0x0240 with normal latency.
- Random loopback: drive the sqrt block's q/remainder for random radicals into this block -> result equals the padded radical with overflow=0, rem_err=0, for 1000 vectors.
